lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter T_SU, default 2, clock cycles RS/DATA are stable before LCD_EN rises.
REQ-002 Parameter T_PW, default 16, clock cycles LCD_EN is held high.
REQ-003 Parameter T_HOLD, default 2, clock cycles RS/DATA are held after LCD_EN falls.
REQ-004 Parameter T_WAIT, default 2000, execution wait for ordinary command/data (40 us at 50 MHz).
REQ-005 Parameter T_LONG, default 82000, execution wait for clear/home commands (1.64 ms at 50 MHz).
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 iCLK  input  1  system clock, 50 MHz.
REQ-008 iRST_N  input  1  asynchronous active-low reset.
REQ-009 iREQ0, iREQ1  input  1 each  requester n wants one LCD byte transfer.
REQ-010 iRS0, iRS1  input  1 each  requester n register select: 0 = command, 1 = data.
REQ-011 iDATA0, iDATA1  input  8 each  requester n byte.
REQ-012 oACK0, oACK1  output  1 each  one-cycle grant/accept pulse to requester n.
REQ-013 oBUSY  output  1  high whenever FSM is not IDLE.
REQ-014 LCD_EN, LCD_RS, LCD_RW  output  1 each  LCD control pins; LCD_RW constant 0 (write only).
REQ-015 LCD_DATA  output  8  LCD data bus, driven from internal register.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT; all other encodings return to IDLE.
REQ-017 IDLE: if any iREQn is high at a clock edge, go to SETUP; latch granted iRSn/iDATAn into LCD_RS/LCD_DATA; assert oACKn for exactly the next cycle.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the port not granted last; with one request, grant it regardless of history.
REQ-019 Only one oACK SHALL be high in any cycle; requests are ignored outside IDLE.
REQ-020 A requester SHALL hold iREQn, iRSn, iDATAn stable until it samples oACKn high, then drop iREQn unless it has another byte.
REQ-021 SETUP lasts T_SU cycles with LCD_EN=0; PULSE lasts T_PW cycles with LCD_EN=1; HOLD lasts T_HOLD cycles with LCD_EN=0.
REQ-022 WAIT lasts T_LONG cycles when the latched byte is a command (RS=0) with value 0x01 or 0x02 (bit 7:2 zero); otherwise T_WAIT cycles.
REQ-023 LCD_RS and LCD_DATA SHALL remain constant from SETUP entry through WAIT exit.
REQ-024 After WAIT the FSM returns to IDLE for at least one cycle; per-byte period = 1 + T_SU + T_PW + T_HOLD + wait cycles.
REQ-025 Delay counting SHALL use a single down-counter wide enough for T_LONG (17 bits at defaults); load value N-1, advance state at zero.
REQ-026 Back-to-back requests from one port while the other idles SHALL be granted consecutively with no starvation of a later request from the other port (it wins the next IDLE).

Reset
REQ-027 On iRST_N low, immediately: state IDLE, LCD_EN 0, LCD_RS 0, LCD_DATA 0x00, LCD_RW 0, oACK0/oACK1 0, oBUSY 0, counter 0.
REQ-028 Round-robin history resets to "port 1 last granted" so port 0 wins the first contended grant.
REQ-029 Reset asserted mid-transfer (including during PULSE) SHALL drop LCD_EN asynchronously; the interrupted byte is lost and not retried.

Structure
REQ-030 Shared package lcd_pkg SHALL hold the FSM state type, the default timing constants, and the clear/home command codes.
REQ-031 One sub-module, lcd_delay_counter (load, count-down, zero flag), SHALL provide all state durations.

Verification
REQ-032 Single request: iREQ0=1, iRS0=1, iDATA0=0x41 -> oACK0 one cycle; LCD_EN high exactly 16 cycles, starting 2 cycles after ACK; LCD_DATA=0x41, LCD_RS=1 throughout; oBUSY low after 2000-cycle WAIT.
REQ-033 Contention: iREQ0 and iREQ1 high from reset, both held -> grants alternate 0,1,0,1; never two ACKs in one cycle.
REQ-034 Long command: iRS1=0, iDATA1=0x01 -> WAIT 82000 cycles; repeat with 0x38 -> WAIT 2000 cycles.
REQ-035 Reset mid-PULSE: assert iRST_N=0 at PULSE cycle 5 -> LCD_EN 0 without waiting for a clock edge, all outputs at reset values; after release, a new request completes normally.
REQ-036 Late request: iREQ1 asserted during port 0 WAIT while iREQ0 stays high -> port 1 granted at next IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus arbiter: FSM states, default
// timing (50 MHz clock) and the slow-executing clear/home command codes.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } lcd_state_e;

   localparam int unsigned T_SU_DEF   = 2;
   localparam int unsigned T_PW_DEF   = 16;
   localparam int unsigned T_HOLD_DEF = 2;
   localparam int unsigned T_WAIT_DEF = 2000;   // 40 us
   localparam int unsigned T_LONG_DEF = 82000;  // 1.64 ms

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Clear and home are the only instructions needing the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that times every FSM state; zero_o flags the last
// cycle of the loaded duration.
module lcd_delay_counter #(
   parameter int unsigned CW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-port round-robin arbiter that serialises byte writes onto an HD44780
// style LCD bus with setup / enable pulse / hold / execution-wait timing.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned T_SU   = T_SU_DEF,
   parameter int unsigned T_PW   = T_PW_DEF,
   parameter int unsigned T_HOLD = T_HOLD_DEF,
   parameter int unsigned T_WAIT = T_WAIT_DEF,
   parameter int unsigned T_LONG = T_LONG_DEF
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iREQ0,
   input  logic       iREQ1,
   input  logic       iRS0,
   input  logic       iRS1,
   input  logic [7:0] iDATA0,
   input  logic [7:0] iDATA1,
   output logic       oACK0,
   output logic       oACK1,
   output logic       oBUSY,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);

   localparam int unsigned T_MAX = max_u(max_u(T_SU, T_PW), max_u(max_u(T_HOLD, T_WAIT), T_LONG));
   localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   lcd_state_e    state_q, state_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          en_q, en_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          last1_q, last1_d;   // 1 = port 1 was granted most recently
   logic          grant1;
   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_zero;

   lcd_delay_counter #(.CW(CW)) u_delay (
      .clk        (iCLK),
      .rst_n      (iRST_N),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   // Port 1 wins when it is alone, or when both request and port 0 went last.
   assign grant1 = iREQ1 && (!iREQ0 || !last1_q);

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      rs_d     = rs_q;
      data_d   = data_q;
      last1_d  = last1_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = '0;

      case (state_q)
         ST_IDLE: begin
            if (iREQ0 || iREQ1) begin
               state_d  = ST_SETUP;
               cnt_load = 1'b1;
               cnt_val  = CW'(T_SU - 1);
               last1_d  = grant1;
               ack0_d   = !grant1;
               ack1_d   = grant1;
               rs_d     = grant1 ? iRS1 : iRS0;
               data_d   = grant1 ? iDATA1 : iDATA0;
            end
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               state_d  = ST_PULSE;
               cnt_load = 1'b1;
               cnt_val  = CW'(T_PW - 1);
            end
         end
         ST_PULSE: begin
            if (cnt_zero) begin
               state_d  = ST_HOLD;
               cnt_load = 1'b1;
               cnt_val  = CW'(T_HOLD - 1);
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_d  = ST_WAIT;
               cnt_load = 1'b1;
               cnt_val  = is_long_cmd(rs_q, data_q) ? CW'(T_LONG - 1) : CW'(T_WAIT - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Enable is registered from the next state so the pin never glitches.
      en_d = (state_d == ST_PULSE);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_IDLE;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         last1_q <= 1'b1;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         last1_q <= last1_d;
      end
   end

   assign oACK0    = ack0_q;
   assign oACK1    = ack1_q;
   assign oBUSY    = (state_q != ST_IDLE);
   assign LCD_EN   = en_q;
   assign LCD_RS   = rs_q;
   assign LCD_RW   = 1'b0;
   assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomised self-checking bench for lcd_bus_arbiter; execution waits are
// shortened so long-command runs stay cheap, all other timing is default.
module tb_lcd_bus_arbiter;

   localparam int T_SU   = 2;
   localparam int T_PW   = 16;
   localparam int T_HOLD = 2;
   localparam int T_WAIT = 100;
   localparam int T_LONG = 500;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       iREQ0 = 1'b0, iREQ1 = 1'b0;
   logic       iRS0 = 1'b0, iRS1 = 1'b0;
   logic [7:0] iDATA0 = 8'h00, iDATA1 = 8'h00;
   logic       oACK0, oACK1, oBUSY, LCD_EN, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA;

   lcd_bus_arbiter #(
      .T_SU(T_SU), .T_PW(T_PW), .T_HOLD(T_HOLD), .T_WAIT(T_WAIT), .T_LONG(T_LONG)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .iREQ0(iREQ0), .iREQ1(iREQ1), .iRS0(iRS0), .iRS1(iRS1),
      .iDATA0(iDATA0), .iDATA1(iDATA1),
      .oACK0(oACK0), .oACK1(oACK1), .oBUSY(oBUSY),
      .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
   );

   always #5 iCLK = ~iCLK;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: pending bytes per requester ({rs, data}) and last grantee.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   int         last_port = 1;

   function automatic logic [13:0] obs();
      return {oBUSY, LCD_EN, LCD_RS, LCD_RW, LCD_DATA, oACK0, oACK1};
   endfunction

   // Requesters present the head of their queue until it is acknowledged.
   task automatic drive();
      iREQ0  = (q0.size() != 0);
      iRS0   = (q0.size() != 0) ? q0[0][8]   : 1'b0;
      iDATA0 = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      iREQ1  = (q1.size() != 0);
      iRS1   = (q1.size() != 0) ? q1[0][8]   : 1'b0;
      iDATA1 = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
   endtask

   task automatic apply_reset();
      iRST_N = 1'b0;
      q0.delete();
      q1.delete();
      drive();
      repeat (3) @(negedge iCLK);
      iRST_N    = 1'b1;
      last_port = 1;
   endtask

   // Called at a negedge with the DUT idle and a request pending: predicts
   // the whole byte transfer cycle by cycle, then the mandatory idle cycle.
   task automatic transfer(input int inj_at, input int inj_port, input logic [8:0] inj_item,
                           output int port);
      logic [8:0]  item;
      logic [13:0] exp;
      int          wait_c;
      int          total;
      port = -1;
      if (q0.size() == 0 && q1.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL xfer_precondition: got no pending request, required at least one");
         return;
      end
      if (q0.size() != 0 && q1.size() != 0) port = (last_port == 1) ? 0 : 1;
      else                                  port = (q0.size() != 0) ? 0 : 1;
      item   = (port == 0) ? q0[0] : q1[0];
      wait_c = (!item[8] && (item[7:0] == 8'h01 || item[7:0] == 8'h02)) ? T_LONG : T_WAIT;
      total  = T_SU + T_PW + T_HOLD + wait_c;
      for (int k = 0; k < total; k++) begin
         @(negedge iCLK);
         exp = {1'b1, (k >= T_SU && k < T_SU + T_PW), item[8], 1'b0, item[7:0],
                (k == 0 && port == 0), (k == 0 && port == 1)};
         n_cmp++;
         if (obs() !== exp) begin
            n_err++;
            $display("FAIL xfer_cycle port%0d k=%0d {busy,en,rs,rw,data,ack0,ack1}: got %h required %h",
                     port, k, obs(), exp);
         end
         if (k == 0) begin
            if (port == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
            drive();
         end
         if (k == inj_at) begin
            if (inj_port == 0) q0.push_back(inj_item);
            else               q1.push_back(inj_item);
            drive();
         end
      end
      last_port = port;
      @(negedge iCLK);
      n_cmp++;
      if ({oBUSY, LCD_EN, LCD_RW, oACK0, oACK1} !== 5'b0) begin
         n_err++;
         $display("FAIL xfer_idle port%0d {busy,en,rw,ack0,ack1}: got %b required 00000",
                  port, {oBUSY, LCD_EN, LCD_RW, oACK0, oACK1});
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if (obs() !== 14'h0) begin
         n_err++;
         $display("FAIL reset_async: got %h required 0000", obs());
      end
      repeat (2) @(negedge iCLK);
      n_cmp++;
      if (obs() !== 14'h0) begin
         n_err++;
         $display("FAIL reset_clocked: got %h required 0000", obs());
      end
      apply_reset();
      repeat (3) @(negedge iCLK);
      n_cmp++;
      if (obs() !== 14'h0) begin
         n_err++;
         $display("FAIL reset_released_idle: got %h required 0000", obs());
      end
   endtask

   task automatic test_single();
      int p;
      q0.push_back({1'b1, 8'h41});
      drive();
      transfer(-1, 0, 9'h0, p);
      n_cmp++;
      if (p != 0 || iREQ0 !== 1'b0) begin
         n_err++;
         $display("FAIL single_grant: got port %0d req0 %b required port 0 req0 0", p, iREQ0);
      end
   endtask

   task automatic test_contention();
      int p;
      int exp_seq[4] = '{0, 1, 0, 1};
      apply_reset();
      q0.push_back({1'b1, 8'h10});
      q0.push_back({1'b1, 8'h11});
      q1.push_back({1'b1, 8'h20});
      q1.push_back({1'b1, 8'h21});
      drive();
      for (int i = 0; i < 4; i++) begin
         transfer(-1, 0, 9'h0, p);
         n_cmp++;
         if (p != exp_seq[i]) begin
            n_err++;
            $display("FAIL contention_order grant %0d: got port %0d required port %0d", i, p, exp_seq[i]);
         end
      end
   endtask

   task automatic test_long_cmd();
      int p;
      q1.push_back({1'b0, 8'h01});
      q1.push_back({1'b0, 8'h38});
      q1.push_back({1'b0, 8'h02});
      q1.push_back({1'b1, 8'h01});
      q1.push_back({1'b0, 8'h03});
      drive();
      for (int i = 0; i < 5; i++) transfer(-1, 0, 9'h0, p);
   endtask

   task automatic test_reset_mid_pulse();
      int p;
      q0.push_back({1'b1, 8'hA5});
      drive();
      for (int k = 0; k <= T_SU + 4; k++) begin
         @(negedge iCLK);
         if (k == 0) begin
            void'(q0.pop_front());
            drive();
         end
      end
      n_cmp++;
      if (LCD_EN !== 1'b1) begin
         n_err++;
         $display("FAIL midpulse_en_before: got %b required 1", LCD_EN);
      end
      #2;
      iRST_N = 1'b0;
      #1;
      n_cmp++;
      if (obs() !== 14'h0) begin
         n_err++;
         $display("FAIL midpulse_async_reset: got %h required 0000", obs());
      end
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLK);
         n_cmp++;
         if (obs() !== 14'h0) begin
            n_err++;
            $display("FAIL midpulse_no_retry cycle %0d: got %h required 0000", i, obs());
         end
      end
      q1.push_back({1'b1, 8'h5A});
      drive();
      transfer(-1, 0, 9'h0, p);
   endtask

   task automatic test_late_request();
      int p;
      int exp_seq[4] = '{0, 1, 0, 0};
      q0.push_back({1'b1, 8'h30});
      q0.push_back({1'b1, 8'h31});
      q0.push_back({1'b1, 8'h32});
      drive();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) transfer(T_SU + T_PW + T_HOLD + 3, 1, {1'b1, 8'h77}, p);
         else        transfer(-1, 0, 9'h0, p);
         n_cmp++;
         if (p != exp_seq[i]) begin
            n_err++;
            $display("FAIL late_request grant %0d: got port %0d required port %0d", i, p, exp_seq[i]);
         end
      end
   endtask

   function automatic logic [8:0] rand_item();
      logic [7:0] d;
      d = ($urandom_range(3) == 0) ? 8'($urandom_range(2, 1)) : 8'($urandom);
      return {1'($urandom), d};
   endfunction

   task automatic test_random();
      int p;
      int inj;
      for (int i = 0; i < 20; i++) begin
         for (int j = $urandom_range(2); j > 0; j--) begin
            if ($urandom_range(1) == 0) q0.push_back(rand_item());
            else                        q1.push_back(rand_item());
         end
         if (q0.size() == 0 && q1.size() == 0) q1.push_back(rand_item());
         drive();
         inj = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(T_SU + T_PW + T_HOLD + 10));
         transfer(inj, int'($urandom_range(1)), rand_item(), p);
      end
      while (q0.size() != 0 || q1.size() != 0) transfer(-1, 0, 9'h0, p);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_long_cmd();
      test_reset_mid_pulse();
      test_late_request();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
